// File: rtl/game_frame_ctrl.sv
// game_frame_ctrl
//   Per-frame sequencer for the player datapath. Each game frame goes
//   REG -> COLLIDE -> APPLY -> DRAW_MAP -> DRAW_CHAR -> IDLE. An internal
//   frame-tick counter sets the pace. The block also picks which renderer
//   owns the VGA port.
//
//   Optional feature: define CTRL_TIMEOUT_EN to add a watchdog on the three
//   wait states. TIMEOUT_CYCLES is declared only in that build. With the macro
//   undefined, wait states block indefinitely and timeout_err is tied to 0.
//
// Parameters
//   FRAME_CYCLES    clock cycles per game frame (>= 2)
//   TIMEOUT_CYCLES  max cycles in any wait state (CTRL_TIMEOUT_EN only)
// Ports
//   clock, resetn         clock (rising edge), asynchronous active-low reset
//   enable                game running; 0 returns to INIT (acted on in IDLE only)
//   collision_done        level, sampled in COLLIDE only
//   map_draw_done         level, sampled in DRAW_MAP only
//   char_draw_done        level, sampled in DRAW_CHAR only
//   init .. draw_char     one-hot state strobes
//   vga_sel               0 = map renderer owns VGA, 1 = character renderer
//   frame_num             completed-frame counter (wraps)
//   frame_overrun         sticky: a tick arrived outside IDLE
//   timeout_err           one-cycle pulse on a watchdog abort
//   state_dbg             raw state register, for checkers
//
// Done inputs use level semantics. There is no valid/ready pair. Each done is
// a level that the FSM samples only in its matching wait state, and a done
// that is already high on entry ends that state after a single cycle.
module game_frame_ctrl #(
  parameter int FRAME_CYCLES = 833333
`ifdef CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        enable,
  input  logic        collision_done,
  input  logic        map_draw_done,
  input  logic        char_draw_done,
  output logic        init,
  output logic        idle,
  output logic        reg_action,
  output logic        check_collision,
  output logic        apply_action,
  output logic        draw_map,
  output logic        draw_char,
  output logic        vga_sel,
  output logic [15:0] frame_num,
  output logic        frame_overrun,
  output logic        timeout_err,
  output logic [2:0]  state_dbg
);

  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FRAME_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_REG       = 3'd2,
    S_COLLIDE   = 3'd3,
    S_APPLY     = 3'd4,
    S_DRAW_MAP  = 3'd5,
    S_DRAW_CHAR = 3'd6
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tick_cnt;
  logic            tick;
  logic            tick_pending;
  logic            in_wait;
  logic            done_match;
  logic            timeout_hit;

  // The counter is frozen in INIT, so the first frame after enable starts a
  // full FRAME_CYCLES after leaving INIT.
  assign tick    = (state != S_INIT) && (tick_cnt == '0);
  assign in_wait = (state == S_COLLIDE) || (state == S_DRAW_MAP) || (state == S_DRAW_CHAR);

  always_comb begin
    done_match = 1'b0;
    case (state)
      S_COLLIDE:   done_match = collision_done;
      S_DRAW_MAP:  done_match = map_draw_done;
      S_DRAW_CHAR: done_match = char_draw_done;
      default:     done_match = 1'b0;
    endcase
  end

`ifdef CTRL_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // wait_cnt counts cycles already spent in the current wait state. It is 0
  // in the entry cycle, so the abort fires at the end of cycle TIMEOUT_CYCLES.
  assign timeout_hit = in_wait && !done_match && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (!in_wait || (state_nxt != state)) wait_cnt <= '0;
      else                                  wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_INIT;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:      if (enable) state_nxt = S_IDLE;
      S_IDLE: begin
        if (!enable)                   state_nxt = S_INIT;
        else if (tick || tick_pending) state_nxt = S_REG;
      end
      S_REG:       state_nxt = S_COLLIDE;
      S_COLLIDE: begin
        if (done_match)       state_nxt = S_APPLY;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_APPLY:     state_nxt = S_DRAW_MAP;
      S_DRAW_MAP: begin
        if (done_match)       state_nxt = S_DRAW_CHAR;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_DRAW_CHAR: if (done_match || timeout_hit) state_nxt = S_IDLE;
      default:     state_nxt = S_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    init            = (state == S_INIT);
    idle            = (state == S_IDLE);
    reg_action      = (state == S_REG);
    check_collision = (state == S_COLLIDE);
    apply_action    = (state == S_APPLY);
    draw_map        = (state == S_DRAW_MAP);
    draw_char       = (state == S_DRAW_CHAR);
    vga_sel         = (state == S_DRAW_CHAR);
    state_dbg       = state;
  end

  // Frame pacing and bookkeeping
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt      <= RELOAD;
      tick_pending  <= 1'b0;
      frame_overrun <= 1'b0;
      frame_num     <= '0;
    end else begin
      if (state == S_INIT || tick_cnt == '0) tick_cnt <= RELOAD;
      else                                   tick_cnt <= tick_cnt - 1'b1;

      // Any number of missed ticks collapses into a single pending frame.
      if (state_nxt == S_INIT) begin
        tick_pending  <= 1'b0;
        frame_overrun <= 1'b0;
      end else if (tick && state != S_IDLE) begin
        tick_pending  <= 1'b1;
        frame_overrun <= 1'b1;
      end else if (state == S_IDLE && state_nxt == S_REG) begin
        tick_pending  <= 1'b0;
      end

      if (state == S_DRAW_CHAR && char_draw_done) frame_num <= frame_num + 16'd1;
    end
  end

endmodule

// File: tb/tb_game_frame_ctrl.sv
module tb_game_frame_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        collision_done = 1'b1;
  logic        map_draw_done = 1'b1;
  logic        char_draw_done = 1'b1;
  logic        init, idle, reg_action, check_collision, apply_action, draw_map, draw_char;
  logic        vga_sel;
  logic [15:0] frame_num;
  logic        frame_overrun, timeout_err;
  logic [2:0]  state_dbg;

  // strobe bit indices
  localparam int I_INIT = 0, I_IDLE = 1, I_REG = 2, I_COL = 3, I_APP = 4, I_MAP = 5, I_CHAR = 6;

  logic [6:0]  strb;
  assign strb = {draw_char, draw_map, apply_action, check_collision, reg_action, idle, init};

  game_frame_ctrl #(
    .FRAME_CYCLES(8)
`ifdef CTRL_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .collision_done(collision_done), .map_draw_done(map_draw_done),
    .char_draw_done(char_draw_done),
    .init(init), .idle(idle), .reg_action(reg_action),
    .check_collision(check_collision), .apply_action(apply_action),
    .draw_map(draw_map), .draw_char(draw_char), .vga_sel(vga_sel),
    .frame_num(frame_num), .frame_overrun(frame_overrun),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // scoreboard
  // entry: {dwell of previous state [7:0], strobes [6:0], vga_sel, frame_num [15:0], overrun, timeout}
  logic [33:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        mon_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
  endtask

  task automatic push(input int d, input int idx, input int fn, input bit ov, input bit to);
    logic [6:0] s;
    s = 7'd1 << idx;
    exp_q.push_back({8'(d), s, (idx == I_CHAR), 16'(fn), ov, to});
  endtask

  // One frame from REG to the following IDLE: dwell before REG, dwell of DRAW_MAP,
  // overrun flag up to DRAW_MAP and from DRAW_CHAR on.
  task automatic push_frame(input int reg_d, input int map_d, input int fn, input bit ov_pre, input bit ov_post);
    push(reg_d, I_REG, fn, ov_pre, 1'b0);
    push(1,     I_COL, fn, ov_pre, 1'b0);
    push(1,     I_APP, fn, ov_pre, 1'b0);
    push(1,     I_MAP, fn, ov_pre, 1'b0);
    push(map_d, I_CHAR, fn, ov_post, 1'b0);
    push(1,     I_IDLE, fn + 1, ov_post, 1'b0);
  endtask

  // monitor: every strobe change is one DUT output event
  logic [6:0] prev_strb;
  int         since;
  always @(negedge clock) begin
    logic [33:0] obs, e;
    if (!mon_on) begin
      prev_strb = strb;
      since = 0;
    end else begin
      since++;
      if (strb !== prev_strb) begin
        obs = {8'(since), strb, vga_sel, frame_num, frame_overrun, timeout_err};
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, obs}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("state_event", {30'd0, obs}, {30'd0, e});
        end
        prev_strb = strb;
        since = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_strobe(input int idx, input string nm);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!strb[idx] && n < 300);
    if (!strb[idx]) check({"wait_", nm}, 64'(strb), 64'(7'd1 << idx));
  endtask

  task automatic wait_frame(input int fn);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(idle && frame_num == 16'(fn)) && n < 300);
    if (!(idle && frame_num == 16'(fn))) check("wait_frame", 64'(frame_num), 64'(fn));
  endtask

  initial begin
    // reset held with enable=1
    repeat (2) @(posedge clock);
    #1;
    check("rst_strobes", 64'(strb), 64'(7'b0000001));
    check("rst_vga_sel", 64'(vga_sel), 64'd0);
    check("rst_frame_num", 64'(frame_num), 64'd0);
    check("rst_overrun", 64'(frame_overrun), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);

    // free-running frames, all done inputs high
    push(1, I_IDLE, 0, 1'b0, 1'b0);
    push_frame(8, 1, 0, 1'b0, 1'b0);
    push_frame(3, 1, 1, 1'b0, 1'b0);
    @(negedge clock);
    #2;
    resetn = 1'b1;
    mon_on = 1'b1;
    wait_frame(2);

    // slow map renderer: ticks missed while drawing
    push_frame(3, 21, 2, 1'b0, 1'b1);
    push_frame(1, 1, 3, 1'b1, 1'b1);
    push_frame(1, 1, 4, 1'b1, 1'b1);
    map_draw_done = 1'b0;
    wait_strobe(I_MAP, "map");
    repeat (20) @(posedge clock);
    #1;
    map_draw_done = 1'b1;
    wait_frame(5);

    // enable dropped during map draw: frame completes, then INIT
    push_frame(3, 1, 5, 1'b1, 1'b1);
    push(1, I_INIT, 6, 1'b0, 1'b0);
    wait_strobe(I_MAP, "map2");
    enable = 1'b0;
    wait_strobe(I_INIT, "init");

    // restart, then reset during character draw
    push(3, I_IDLE, 6, 1'b0, 1'b0);
    push(8, I_REG, 6, 1'b0, 1'b0);
    push(1, I_COL, 6, 1'b0, 1'b0);
    push(1, I_APP, 6, 1'b0, 1'b0);
    push(1, I_MAP, 6, 1'b0, 1'b0);
    push(1, I_CHAR, 6, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    enable = 1'b1;
    char_draw_done = 1'b0;
    wait_strobe(I_CHAR, "char");
    #2;
    mon_on = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_rst_strobes", 64'(strb), 64'(7'b0000001));
    check("async_rst_vga_sel", 64'(vga_sel), 64'd0);
    check("async_rst_frame_num", 64'(frame_num), 64'd0);
    check("async_rst_overrun", 64'(frame_overrun), 64'd0);

    // collision detector never finishes
    collision_done = 1'b0;
    char_draw_done = 1'b1;
    push(1, I_IDLE, 0, 1'b0, 1'b0);
    push(8, I_REG, 0, 1'b0, 1'b0);
    push(1, I_COL, 0, 1'b0, 1'b0);
`ifdef CTRL_TIMEOUT_EN
    push(16, I_IDLE, 0, 1'b1, 1'b1);
`endif
    @(negedge clock);
    #2;
    resetn = 1'b1;
    mon_on = 1'b1;
    wait_strobe(I_COL, "collide");
`ifdef CTRL_TIMEOUT_EN
    wait_strobe(I_IDLE, "timeout_idle");
    #2;
    mon_on = 1'b0;
    check("timeout_pulse", 64'(timeout_err), 64'd1);
    @(negedge clock);
    check("timeout_pulse_end", 64'(timeout_err), 64'd0);
`else
    repeat (40) @(negedge clock);
    check("collide_hold", 64'(strb), 64'(7'b0001000));
    check("no_timeout", 64'(timeout_err), 64'd0);
`endif
    #2;
    mon_on = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
